vbsc_chain: RTL



---
 rtl/vbsc_chain_pkg.sv | 23 ++
 rtl/vbsc_chain_cell.sv | 58 +++++
 rtl/vbsc_chain.sv | 113 +++++++++++
 3 files changed

// File: rtl/vbsc_chain_pkg.sv
// Shared mode codes and cell layout for the virtual boundary-scan chain.
// Optional IDCODE register is enabled by defining VBSC_IDCODE_EN.
package vbsc_chain_pkg;

   typedef enum logic [2:0] {
      MODE_BYPASS = 3'd0,
      MODE_SAMPLE = 3'd1,
      MODE_EXTEST = 3'd2,
      MODE_INTEST = 3'd3,
      MODE_IDCODE = 3'd4
   } mode_e;

   localparam int VBSC_NBIT    = 3;
   localparam int VBSC_BIT_IN  = 0;
   localparam int VBSC_BIT_OE  = 1;
   localparam int VBSC_BIT_OUT = 2;

   // Modes that route the serial path through the cell chain
   function automatic logic is_scan(input mode_e m);
      return m inside {MODE_SAMPLE, MODE_EXTEST, MODE_INTEST};
   endfunction

endpackage

// File: rtl/vbsc_chain_cell.sv
// One 3-bit boundary-scan cell: capture/shift stage, update regs, pin mux.
// Serial data flows from si (high bit) toward so (bit 0).
module vbsc_cell
   import vbsc_chain_pkg::*;
(
   input  logic  tck,
   input  logic  rst_n,
   input  logic  si,
   input  mode_e mode,
   input  logic  cdr,
   input  logic  sdr,
   input  logic  udr,
   input  logic  pin_in,
   input  logic  core_oe,
   input  logic  core_out,
   output logic  so,
   output logic  pin_oe,
   output logic  pin_out,
   output logic  core_in
);

   logic [VBSC_NBIT-1:0] sr;
   logic                 upd_in;
   logic                 upd_oe;
   logic                 upd_out;
   logic                 scan;

   assign scan = is_scan(mode);

   always_ff @(posedge tck) begin
      if (!rst_n) begin
         sr      <= '0;
         upd_in  <= 1'b0;
         upd_oe  <= 1'b0;
         upd_out <= 1'b0;
      end else if (scan) begin
         if (cdr) begin
            sr[VBSC_BIT_IN]  <= (mode == MODE_INTEST) ? upd_in : pin_in;
            sr[VBSC_BIT_OE]  <= core_oe;
            sr[VBSC_BIT_OUT] <= core_out;
         end else if (sdr) begin
            sr <= {si, sr[VBSC_NBIT-1:1]};
         end
         // Update samples the pre-edge shift contents
         if (udr) begin
            upd_in  <= sr[VBSC_BIT_IN];
            upd_oe  <= sr[VBSC_BIT_OE];
            upd_out <= sr[VBSC_BIT_OUT];
         end
      end
   end

   assign so      = sr[0];
   assign pin_oe  = (mode == MODE_EXTEST) ? upd_oe  : core_oe;
   assign pin_out = (mode == MODE_EXTEST) ? upd_out : core_out;
   assign core_in = (mode == MODE_INTEST) ? upd_in  : pin_in;

endmodule

// File: rtl/vbsc_chain.sv
// Virtual boundary-scan chain top: mode decode, bypass/id regs, tdo select.
// Define VBSC_IDCODE_EN to build the 32-bit IDCODE register on code 4.
module vbsc_chain
   import vbsc_chain_pkg::*;
#(
   parameter int unsigned VBSC_NUM = 4,
   parameter int unsigned IR_W     = 3,
   parameter logic [31:0] IDCODE   = 32'h0000_10DD
) (
   input  logic                tck,
   input  logic                rst_n,
   input  logic                tdi,
   output logic                tdo,
   input  logic [IR_W-1:0]     ir_in,
   output logic [IR_W-1:0]     ir_out,
   input  logic                vjtag_cdr,
   input  logic                vjtag_sdr,
   input  logic                vjtag_udr,
   input  logic [VBSC_NUM-1:0] pin_in,
   output logic [VBSC_NUM-1:0] pin_oe,
   output logic [VBSC_NUM-1:0] pin_out,
   input  logic [VBSC_NUM-1:0] core_oe,
   input  logic [VBSC_NUM-1:0] core_out,
   output logic [VBSC_NUM-1:0] core_in,
   output logic                scan_active
);

   mode_e               mode;
   mode_e               mode_d;
   logic                byp;
   logic [VBSC_NUM:0]   chain;

   always_comb begin
      mode_d = MODE_BYPASS;
      if (ir_in == IR_W'(MODE_SAMPLE))      mode_d = MODE_SAMPLE;
      else if (ir_in == IR_W'(MODE_EXTEST)) mode_d = MODE_EXTEST;
      else if (ir_in == IR_W'(MODE_INTEST)) mode_d = MODE_INTEST;
`ifdef VBSC_IDCODE_EN
      else if (ir_in == IR_W'(MODE_IDCODE)) mode_d = MODE_IDCODE;
`endif
   end

   always_ff @(posedge tck) begin
      if (!rst_n) mode <= MODE_BYPASS;
      else        mode <= mode_d;
   end

   assign ir_out      = IR_W'(mode);
   assign scan_active = (mode == MODE_EXTEST) || (mode == MODE_INTEST);

   always_ff @(posedge tck) begin
      if (!rst_n) begin
         byp <= 1'b0;
      end else if (mode == MODE_BYPASS) begin
         if (vjtag_cdr)      byp <= 1'b0;
         else if (vjtag_sdr) byp <= tdi;
      end
   end

`ifdef VBSC_IDCODE_EN
   logic [31:0] id;

   always_ff @(posedge tck) begin
      if (!rst_n) begin
         id <= '0;
      end else if (mode == MODE_IDCODE) begin
         if (vjtag_cdr)      id <= IDCODE;
         else if (vjtag_sdr) id <= {tdi, id[31:1]};
      end
   end
`else
   logic unused_idcode;
   assign unused_idcode = ^IDCODE;
`endif

   assign chain[VBSC_NUM] = tdi;

   for (genvar i = 0; i < VBSC_NUM; i++) begin : g_cell
      vbsc_cell u_cell (
         .tck      (tck),
         .rst_n    (rst_n),
         .si       (chain[i+1]),
         .mode     (mode),
         .cdr      (vjtag_cdr),
         .sdr      (vjtag_sdr),
         .udr      (vjtag_udr),
         .pin_in   (pin_in[i]),
         .core_oe  (core_oe[i]),
         .core_out (core_out[i]),
         .so       (chain[i]),
         .pin_oe   (pin_oe[i]),
         .pin_out  (pin_out[i]),
         .core_in  (core_in[i])
      );
   end

   always_comb begin
      tdo = 1'b0;
      if (vjtag_sdr) begin
         unique case (mode)
            MODE_BYPASS: tdo = byp;
            MODE_SAMPLE,
            MODE_EXTEST,
            MODE_INTEST: tdo = chain[0];
`ifdef VBSC_IDCODE_EN
            MODE_IDCODE: tdo = id[0];
`endif
            default:     tdo = 1'b0;
         endcase
      end
   end

endmodule
